// File: rtl/decoder3_8.sv
// Registered 3-to-8 one-hot decoder with enable and optional active-low output.
// y and y_valid are the only state; both update on the rising clk edge and clear asynchronously on rst.
module decoder3_8 #(
  parameter int unsigned ACTIVE_LOW = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] i,
  output logic [7:0] y,
  output logic       y_valid
);

  // The deasserted level of every line: all zeros, or all ones when the outputs are active-low.
  localparam logic [7:0] Y_IDLE = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [7:0] y_next;

  always_comb begin
    y_next = '0;
    if (en) begin
      y_next = 8'b0000_0001 << i;
    end
    if (ACTIVE_LOW != 0) begin
      y_next = ~y_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y       <= Y_IDLE;
      y_valid <= 1'b0;
    end else begin
      y       <= y_next;
      y_valid <= en;
    end
  end

endmodule

// File: tb/tb_decoder3_8.sv
// Bench for decoder3_8: active-high and active-low builds driven in parallel from directed vectors.
module tb_decoder3_8;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] i;
  logic [7:0] y_hi;
  logic       v_hi;
  logic [7:0] y_lo;
  logic       v_lo;

  int unsigned errors;
  int unsigned checks;

  decoder3_8 #(.ACTIVE_LOW(0)) dut_hi (
    .clk(clk), .rst(rst), .en(en), .i(i), .y(y_hi), .y_valid(v_hi)
  );

  decoder3_8 #(.ACTIVE_LOW(1)) dut_lo (
    .clk(clk), .rst(rst), .en(en), .i(i), .y(y_lo), .y_valid(v_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [2:0] i;
    logic [7:0] exp_y;
    logic       exp_v;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Checks both builds against the active-high expectation.
  task automatic chk_both(input string name, input logic [7:0] exp_y, input logic exp_v);
    chk({name, " y"}, y_hi, exp_y);
    chk({name, " valid"}, {7'd0, v_hi}, {7'd0, exp_v});
    chk({name, " y_lo"}, y_lo, ~exp_y);
    chk({name, " valid_lo"}, {7'd0, v_lo}, {7'd0, exp_v});
  endtask

  task automatic step(input logic e, input logic [2:0] sel);
    @(negedge clk);
    en = e;
    i  = sel;
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0;
    en  = 1'b1;
    i   = 3'b110;

    // Reach a decoded state, then show reset acting without a clock edge.
    step(1'b1, 3'b110);
    chk_both("pre-reset", 8'h40, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_both("async reset", 8'h00, 1'b0);
    @(posedge clk);
    #1;
    chk_both("reset held", 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Sweep, disable, re-enable, and en toggling every cycle.
    vecs.push_back('{1'b1, 3'd0, 8'h01, 1'b1});
    vecs.push_back('{1'b1, 3'd1, 8'h02, 1'b1});
    vecs.push_back('{1'b1, 3'd2, 8'h04, 1'b1});
    vecs.push_back('{1'b1, 3'd3, 8'h08, 1'b1});
    vecs.push_back('{1'b1, 3'd4, 8'h10, 1'b1});
    vecs.push_back('{1'b1, 3'd5, 8'h20, 1'b1});
    vecs.push_back('{1'b1, 3'd6, 8'h40, 1'b1});
    vecs.push_back('{1'b1, 3'd7, 8'h80, 1'b1});
    vecs.push_back('{1'b0, 3'd3, 8'h00, 1'b0});
    vecs.push_back('{1'b1, 3'd3, 8'h08, 1'b1});
    vecs.push_back('{1'b0, 3'd7, 8'h00, 1'b0});
    vecs.push_back('{1'b1, 3'd5, 8'h20, 1'b1});
    vecs.push_back('{1'b0, 3'd5, 8'h00, 1'b0});
    vecs.push_back('{1'b1, 3'd0, 8'h01, 1'b1});
    vecs.push_back('{1'b0, 3'd0, 8'h00, 1'b0});

    for (int k = 0; k < vecs.size(); k++) begin
      step(vecs[k].en, vecs[k].i);
      chk_both($sformatf("vec%0d", k), vecs[k].exp_y, vecs[k].exp_v);
      chk($sformatf("vec%0d popcount", k), 8'($countones(y_hi)), vecs[k].exp_v ? 8'd1 : 8'd0);
    end

    // Mid-cycle change of i must not reach y before the next edge.
    step(1'b1, 3'b001);
    chk_both("lat before", 8'h02, 1'b1);
    #2;
    i = 3'b010;
    #1;
    chk_both("lat mid", 8'h02, 1'b1);
    @(negedge clk);
    chk_both("lat negedge", 8'h02, 1'b1);
    @(posedge clk);
    #1;
    chk_both("lat after", 8'h04, 1'b1);

    // Reset pulse between edges during a sweep.
    step(1'b1, 3'b011);
    chk_both("sweep 3", 8'h08, 1'b1);
    @(negedge clk);
    i = 3'b100;
    #1;
    rst = 1'b1;
    #1;
    chk_both("mid reset", 8'h00, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    chk_both("post release", 8'h00, 1'b0);
    @(posedge clk);
    #1;
    chk_both("resume", 8'h10, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
